// File: rtl/axi4_pkg.sv
// Shared AXI4 master definitions: FSM states, response codes, 4 KB page mask.
package axi4_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AW,
        W,
        B,
        AR,
        R,
        ERR
    } axi_state_t;

    localparam logic [1:0]  OKAY          = 2'b00;
    localparam logic [1:0]  SLVERR        = 2'b10;

    // Byte offset within a 4 KB page; bursts must not step past MASK+1.
    localparam logic [31:0] BOUNDARY_MASK = 32'h0000_0FFF;

    // Worst-of-two response, used to fold per-beat read responses.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi4_master.sv
// Single-outstanding AXI4 burst master: user command/beat streams to AXI4 channels.
module axi4_master
    import axi4_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,

    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,

    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,

    output logic                  done,
    output logic [1:0]            resp,

    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,

    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,

    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,

    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,

    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    axi_state_t            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [7:0]            beat_cnt;
    logic                  proto_err;

    logic                  size_bad;
    logic                  page_cross;
    logic [31:0]           page_off;
    logic [31:0]           burst_bytes;
    logic                  w_hs;
    logic                  r_hs;

    // Command legality: transfer size must fit the bus, burst must stay in one 4 KB page
    always_comb begin
        page_off    = 32'(cmd_addr) & BOUNDARY_MASK;
        burst_bytes = (32'(cmd_len) + 32'd1) << cmd_size;
        size_bad    = cmd_size > MAX_SIZE;
        page_cross  = (page_off + burst_bytes) > (BOUNDARY_MASK + 32'd1);
    end

    // Address channels share one set of burst registers; only one is ever valid
    assign AWADDR   = addr_q;
    assign AWLEN    = len_q;
    assign AWSIZE   = size_q;
    assign ARADDR   = addr_q;
    assign ARLEN    = len_q;
    assign ARSIZE   = size_q;

    // Data channels are combinational pass-throughs gated by the active state
    assign WVALID   = (state == W) && wr_valid;
    assign wr_ready = (state == W) && WREADY;
    assign WDATA    = wr_data;
    assign WLAST    = (state == W) && (beat_cnt == len_q);
    assign RREADY   = (state == R) && rd_ready;
    assign rd_valid = (state == R) && RVALID;
    assign rd_data  = RDATA;
    assign rd_last  = (state == R) && RLAST;

    assign w_hs     = WVALID && WREADY;
    assign r_hs     = RVALID && RREADY;

    // Burst sequencing FSM with registered handshake and status outputs
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            AWVALID   <= 1'b0;
            ARVALID   <= 1'b0;
            BREADY    <= 1'b0;
            done      <= 1'b0;
            resp      <= OKAY;
            beat_cnt  <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            proto_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // cmd_ready is held low for the cycle in which done pulses
                    if (cmd_ready && cmd_valid) begin
                        cmd_ready <= 1'b0;
                        addr_q    <= cmd_addr;
                        len_q     <= cmd_len;
                        size_q    <= cmd_size;
                        beat_cnt  <= '0;
                        resp      <= OKAY;
                        proto_err <= 1'b0;
                        if (size_bad || page_cross) begin
                            state <= ERR;
                        end else if (cmd_write) begin
                            state   <= AW;
                            AWVALID <= 1'b1;
                        end else begin
                            state   <= AR;
                            ARVALID <= 1'b1;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                AW: begin
                    if (AWREADY) begin
                        AWVALID <= 1'b0;
                        state   <= W;
                    end
                end
                W: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (WLAST) begin
                            state  <= B;
                            BREADY <= 1'b1;
                        end
                    end
                end
                B: begin
                    if (BVALID) begin
                        BREADY <= 1'b0;
                        resp   <= BRESP;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                end
                AR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        state   <= R;
                    end
                end
                R: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        // Missing RLAST is remembered so a late RLAST still ends as SLVERR
                        if (beat_cnt == len_q && !RLAST) begin
                            proto_err <= 1'b1;
                        end
                        if (RLAST) begin
                            done  <= 1'b1;
                            state <= IDLE;
                            resp  <= (proto_err || beat_cnt != len_q) ? SLVERR
                                                                      : resp_max(resp, RRESP);
                        end else begin
                            resp  <= resp_max(resp, RRESP);
                        end
                    end
                end
                ERR: begin
                    resp  <= SLVERR;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_master.sv
// Self-checking bench for axi4_master with a behavioural memory slave and scoreboard.
module tb_axi4_master;

    logic        ACLK;
    logic        ARESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done;
    logic [1:0]  resp;
    logic [15:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic        AWVALID, AWREADY, ARVALID, ARREADY;
    logic [31:0] WDATA, RDATA;
    logic        WLAST, WVALID, WREADY;
    logic [1:0]  BRESP, RRESP;
    logic        BVALID, BREADY;
    logic        RLAST, RVALID, RREADY;

    int errors = 0;
    int checks = 0;

    // Scenario knobs for the slave and the user side
    int          cfg_aw_stall   = 0;
    bit          cfg_w_toggle   = 0;
    int          cfg_rlast_adj  = 0;
    int          cfg_rresp_beat = -1;
    logic [1:0]  cfg_rresp_val  = 2'b00;
    bit          rd_toggle      = 0;
    bit          no_bus         = 0;

    // Scoreboard queues filled by the model
    logic [32:0] exp_w[$];
    logic [32:0] exp_rd[$];
    logic [1:0]  exp_done[$];
    logic [31:0] ref_mem[int];

    axi4_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .resp(resp),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
        end
    endtask

    // ---------------- behavioural slave: 4 KB word memory ----------------
    logic [31:0] slv_mem [0:1023];
    logic [15:0] w_addr, r_addr;
    int          w_cnt, r_cnt, r_last_idx, aw_wait;
    bit          r_active;

    always @(posedge ACLK) begin : slave
        int widx;
        if (!ARESETn) begin
            AWREADY <= 1'b0; ARREADY <= 1'b0; WREADY <= 1'b1;
            BVALID <= 1'b0; BRESP <= 2'b00;
            RVALID <= 1'b0; RLAST <= 1'b0; RDATA <= '0; RRESP <= 2'b00;
            r_active <= 1'b0; aw_wait <= 0; w_cnt <= 0; r_cnt <= 0;
            w_addr <= '0; r_addr <= '0; r_last_idx <= 0;
            for (int i = 0; i < 1024; i++) slv_mem[i] <= '0;
        end else begin
            if (AWVALID && AWREADY) begin
                AWREADY <= 1'b0; aw_wait <= 0; w_addr <= AWADDR; w_cnt <= 0;
            end else if (AWVALID) begin
                if (aw_wait >= cfg_aw_stall) AWREADY <= 1'b1;
                else aw_wait <= aw_wait + 1;
            end
            WREADY <= cfg_w_toggle ? ~WREADY : 1'b1;
            if (BVALID && BREADY) BVALID <= 1'b0;
            if (WVALID && WREADY) begin
                widx = int'(w_addr >> 2) + w_cnt;
                if (widx < 1024) slv_mem[widx] <= WDATA;
                w_cnt <= w_cnt + 1;
                if (WLAST) begin
                    BVALID <= 1'b1;
                    BRESP  <= (widx < 1024) ? 2'b00 : 2'b10;
                end
            end
            if (ARVALID && ARREADY) begin
                ARREADY <= 1'b0; r_addr <= ARADDR; r_cnt <= 0;
                r_last_idx <= int'(ARLEN) + cfg_rlast_adj; r_active <= 1'b1;
            end else if (ARVALID) begin
                ARREADY <= 1'b1;
            end
            if (r_active && (!RVALID || RREADY)) begin
                if (r_cnt <= r_last_idx) begin
                    widx = int'(r_addr >> 2) + r_cnt;
                    RVALID <= 1'b1;
                    RLAST  <= (r_cnt == r_last_idx);
                    if (widx < 1024) begin
                        RDATA <= slv_mem[widx];
                        RRESP <= (r_cnt == cfg_rresp_beat) ? cfg_rresp_val : 2'b00;
                    end else begin
                        RDATA <= '0;
                        RRESP <= 2'b10;
                    end
                    r_cnt <= r_cnt + 1;
                end else begin
                    RVALID <= 1'b0; RLAST <= 1'b0; r_active <= 1'b0;
                end
            end
        end
    end

    // ---------------- model: expected beats and completion per command ----------------
    task automatic model_cmd(input bit wr, input int addr, input int len, input int size, input int base);
        int         nb, word;
        logic [1:0] acc, br;
        bit         bad;
        bad = (size > 2) || ((addr % 4096) + ((len + 1) << size) > 4096);
        if (bad) begin
            exp_done.push_back(2'b10);
            return;
        end
        if (wr) begin
            br = 2'b00;
            for (int i = 0; i <= len; i++) begin
                word = addr / 4 + i;
                exp_w.push_back({(i == len), 32'(base + i)});
                if (word < 1024) ref_mem[word] = 32'(base + i);
                br = (word < 1024) ? 2'b00 : 2'b10;
            end
            exp_done.push_back(br);
        end else begin
            nb  = len + 1 + cfg_rlast_adj;
            acc = 2'b00;
            for (int i = 0; i < nb; i++) begin
                logic [31:0] d;
                logic [1:0]  r;
                word = addr / 4 + i;
                d = (word < 1024 && ref_mem.exists(word)) ? ref_mem[word] : 32'd0;
                r = (word >= 1024) ? 2'b10 : ((i == cfg_rresp_beat) ? cfg_rresp_val : 2'b00);
                if (r > acc) acc = r;
                exp_rd.push_back({(i == nb - 1), d});
            end
            exp_done.push_back((cfg_rlast_adj != 0) ? 2'b10 : acc);
        end
    endtask

    // ---------------- compare process ----------------
    initial begin : compare
        logic        p_aw, p_ar, p_done;
        logic [15:0] p_awaddr, p_araddr;
        logic [7:0]  p_awlen, p_arlen;
        logic [32:0] e;
        logic [1:0]  ed;
        p_aw = 0; p_ar = 0; p_done = 0;
        p_awaddr = '0; p_araddr = '0; p_awlen = '0; p_arlen = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                p_aw = 0; p_ar = 0; p_done = 0;
            end else begin
                if (WVALID && WREADY) begin
                    if (exp_w.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL w_beat_unexpected: got data 0x%0h, expected no beat", WDATA);
                    end else begin
                        e = exp_w.pop_front();
                        chk("w_data", WDATA, e[31:0]);
                        chk("w_last", 32'(WLAST), 32'(e[32]));
                    end
                end
                if (rd_valid && rd_ready) begin
                    if (exp_rd.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rd_beat_unexpected: got data 0x%0h, expected no beat", rd_data);
                    end else begin
                        e = exp_rd.pop_front();
                        chk("rd_data", rd_data, e[31:0]);
                        chk("rd_last", 32'(rd_last), 32'(e[32]));
                    end
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL done_unexpected: got resp %0d, expected no done", resp);
                    end else begin
                        ed = exp_done.pop_front();
                        chk("done_resp", 32'(resp), 32'(ed));
                    end
                    chk("done_cmd_ready_low", 32'(cmd_ready), 32'd0);
                end
                if (p_done) chk("done_one_cycle", 32'(done), 32'd0);
                if (p_aw) begin
                    chk("aw_valid_held", 32'(AWVALID), 32'd1);
                    chk("aw_addr_stable", 32'(AWADDR), 32'(p_awaddr));
                    chk("aw_len_stable", 32'(AWLEN), 32'(p_awlen));
                end
                if (p_ar) begin
                    chk("ar_valid_held", 32'(ARVALID), 32'd1);
                    chk("ar_addr_stable", 32'(ARADDR), 32'(p_araddr));
                    chk("ar_len_stable", 32'(ARLEN), 32'(p_arlen));
                end
                if (no_bus) chk("no_bus_valid", 32'({AWVALID, ARVALID, WVALID}), 32'd0);
                p_aw = AWVALID && !AWREADY; p_awaddr = AWADDR; p_awlen = AWLEN;
                p_ar = ARVALID && !ARREADY; p_araddr = ARADDR; p_arlen = ARLEN;
                p_done = done;
            end
        end
    end

    // rd_ready either held high or toggled every cycle
    initial begin
        rd_ready = 1'b1;
        forever begin
            @(posedge ACLK); #1;
            rd_ready = rd_toggle ? ~rd_ready : 1'b1;
        end
    end

    // ---------------- user-side drivers (all return at posedge+1) ----------------
    task automatic issue_cmd(input logic wr, input logic [15:0] a, input logic [7:0] l, input logic [2:0] s);
        logic acc;
        acc = 1'b0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_size = s;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge ACLK); acc = cmd_ready;
            @(posedge ACLK); #1;
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout: got cmd_ready 0, expected 1 within 20 cycles");
        end
    endtask

    task automatic send_wbeats(input int n, input int base);
        logic hs;
        for (int b = 0; b < n; b++) begin
            wr_valid = 1'b1; wr_data = 32'(base + b); hs = 1'b0;
            for (int i = 0; i < 50 && !hs; i++) begin
                @(negedge ACLK); hs = wr_valid && wr_ready;
                @(posedge ACLK); #1;
            end
            if (!hs) begin
                checks++; errors++;
                $display("FAIL w_beat_timeout: got no wr_ready, expected beat %0d accepted", b);
                wr_valid = 1'b0;
                return;
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge ACLK); got = done;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: got no done, expected done within %0d cycles", nm, budget);
        end
        @(posedge ACLK); #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : main
        logic hs;
        ARESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_len = '0; cmd_size = '0; wr_valid = 1'b0; wr_data = '0;

        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awvalid", 32'(AWVALID), 32'd0);
        chk("rst_arvalid", 32'(ARVALID), 32'd0);
        chk("rst_bready", 32'(BREADY), 32'd0);
        chk("rst_rready", 32'(RREADY), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_resp", 32'(resp), 32'd0);
        chk("rst_awaddr", 32'(AWADDR), 32'd0);
        chk("rst_awlen", 32'(AWLEN), 32'd0);
        chk("rst_awsize", 32'(AWSIZE), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        ARESETn = 1'b1;
        chk("rel_cmd_ready_before_edge", 32'(cmd_ready), 32'd0);
        @(posedge ACLK); #1;
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write burst 0x0010, len 3, data A0..A3
        model_cmd(1, 'h10, 3, 2, 'hA0);
        issue_cmd(1'b1, 16'h0010, 8'd3, 3'd2);
        send_wbeats(4, 'hA0);
        wait_done(30, "wr_done");
        chk("wr_resp_lit", 32'(resp), 32'd0);
        chk("slv_mem_0x10", slv_mem[4], 32'hA0);
        chk("slv_mem_0x1c", slv_mem[7], 32'hA3);

        // Read-back
        model_cmd(0, 'h10, 3, 2, 0);
        issue_cmd(1'b0, 16'h0010, 8'd3, 3'd2);
        wait_done(30, "rd_done");
        chk("rd_resp_lit", 32'(resp), 32'd0);

        // Burst ending exactly on the 4 KB line, with AWREADY stalled and WREADY toggling
        cfg_aw_stall = 5; cfg_w_toggle = 1;
        model_cmd(1, 'hFF8, 1, 2, 'hB0);
        issue_cmd(1'b1, 16'h0FF8, 8'd1, 3'd2);
        send_wbeats(2, 'hB0);
        wait_done(40, "edge_wr_done");
        cfg_aw_stall = 0; cfg_w_toggle = 0;
        chk("slv_mem_0xffc", slv_mem[1023], 32'hB1);

        // Read with rd_ready toggling every cycle
        rd_toggle = 1;
        model_cmd(0, 'h10, 3, 2, 0);
        issue_cmd(1'b0, 16'h0010, 8'd3, 3'd2);
        wait_done(40, "toggle_rd_done");
        rd_toggle = 0;

        // 4 KB crossing write: error without any bus activity
        no_bus = 1;
        model_cmd(1, 'hFFC, 1, 2, 0);
        issue_cmd(1'b1, 16'h0FFC, 8'd1, 3'd2);
        wait_done(2, "cross_done_latency");
        chk("cross_resp_lit", 32'(resp), 32'd2);

        // Oversized transfer size
        model_cmd(0, 'h0, 0, 3, 0);
        issue_cmd(1'b0, 16'h0000, 8'd0, 3'd3);
        wait_done(2, "size_done_latency");
        @(posedge ACLK); #1;
        no_bus = 0;

        // Read beyond memory depth
        model_cmd(0, 'h1000, 1, 2, 0);
        issue_cmd(1'b0, 16'h1000, 8'd1, 3'd2);
        wait_done(30, "oor_rd_done");
        chk("oor_resp_lit", 32'(resp), 32'd2);

        // EXOKAY on one beat must be the folded result
        cfg_rresp_beat = 2; cfg_rresp_val = 2'b01;
        model_cmd(0, 'h10, 3, 2, 0);
        issue_cmd(1'b0, 16'h0010, 8'd3, 3'd2);
        wait_done(30, "rresp_max_done");
        chk("rresp_max_lit", 32'(resp), 32'd1);
        cfg_rresp_beat = -1; cfg_rresp_val = 2'b00;

        // Early and late RLAST from the slave
        cfg_rlast_adj = -1;
        model_cmd(0, 'h10, 3, 2, 0);
        issue_cmd(1'b0, 16'h0010, 8'd3, 3'd2);
        wait_done(30, "early_rlast_done");
        chk("early_rlast_lit", 32'(resp), 32'd2);
        cfg_rlast_adj = 1;
        model_cmd(0, 'h10, 3, 2, 0);
        issue_cmd(1'b0, 16'h0010, 8'd3, 3'd2);
        wait_done(30, "late_rlast_done");
        chk("late_rlast_lit", 32'(resp), 32'd2);
        cfg_rlast_adj = 0;

        // Reset during the second W beat
        exp_w.push_back({1'b0, 32'hC0});
        issue_cmd(1'b1, 16'h0040, 8'd3, 3'd2);
        wr_valid = 1'b1; wr_data = 32'hC0; hs = 1'b0;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge ACLK); hs = wr_valid && wr_ready;
            @(posedge ACLK); #1;
        end
        chk("mid_rst_first_beat", 32'(hs), 32'd1);
        wr_data = 32'hC1; ARESETn = 1'b0;
        @(posedge ACLK); #1;
        chk("mid_rst_valids", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY, rd_valid}), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        wr_valid = 1'b0;
        exp_w.delete(); exp_rd.delete(); exp_done.delete(); ref_mem.delete();
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        model_cmd(1, 'h40, 0, 2, 'hD0);
        issue_cmd(1'b1, 16'h0040, 8'd0, 3'd2);
        send_wbeats(1, 'hD0);
        wait_done(30, "post_rst_wr_done");
        model_cmd(0, 'h40, 0, 2, 0);
        issue_cmd(1'b0, 16'h0040, 8'd0, 3'd2);
        wait_done(30, "post_rst_rd_done");
        chk("post_rst_resp_lit", 32'(resp), 32'd0);

        repeat (3) @(posedge ACLK);
        #1;
        chk("exp_w_drained", 32'(exp_w.size()), 32'd0);
        chk("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
        chk("exp_done_drained", 32'(exp_done.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi4_master.md
AXI4_MASTER -- requirements
Module: axi4_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the width of the data bus and command data ports.
REQ-002 Parameter ADDR_WIDTH, default 16, sets the byte address width.
REQ-003 ACLK  in  1  the single clock; all logic is on its rising edge.
REQ-004 ARESETn  in  1  reset, synchronous and active-low.
REQ-005 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; a command is accepted when both are high.
REQ-006 cmd_write  in  1  command type: 1 = write burst, 0 = read burst.
REQ-007 cmd_addr / cmd_len / cmd_size  in  ADDR_WIDTH / 8 / 3  burst start byte address, AxLEN (beats minus 1) and AxSIZE.
REQ-008 wr_valid / wr_ready / wr_data  in / out / in  1 / 1 / DATA_WIDTH  write-beat stream from the user.
REQ-009 rd_valid / rd_ready / rd_data / rd_last  out / in / out / out  1 / 1 / DATA_WIDTH / 1  read-beat stream to the user.
REQ-010 done / resp  out / out  1 / 2  completion pulse and final response.
REQ-011 AWADDR, AWLEN, AWSIZE, AWVALID (out) and AWREADY (in) form the write-address channel.
REQ-012 WDATA, WLAST, WVALID (out) and WREADY (in) form the write-data channel.
REQ-013 BRESP, BVALID (in) and BREADY (out) form the write-response channel.
REQ-014 ARADDR, ARLEN, ARSIZE, ARVALID (out) and ARREADY (in) form the read-address channel.
REQ-015 RDATA, RRESP, RLAST, RVALID (in) and RREADY (out) form the read-data channel.
REQ-016 Channel signal widths SHALL match the AXI4 slave in this codebase: address ADDR_WIDTH, length 8, size 3, response 2.

Function
REQ-017 The FSM SHALL have the states IDLE, AW, W, B, AR, R and ERR, with at most one outstanding transaction.
REQ-018 IDLE SHALL assert cmd_ready; an accepted command SHALL be registered, clear the beat counter and the response accumulator, and move to AW (write) or AR (read).
REQ-019 A command with cmd_size > log2(DATA_WIDTH/8), or with a burst that crosses a 4 KB boundary, SHALL go to ERR and SHALL NOT drive any bus valid.
REQ-020 ERR SHALL pulse done for one cycle with resp = 2'b10 (SLVERR) and then return to IDLE.
REQ-021 AW/AR SHALL hold AxVALID high with stable AxADDR/AxLEN/AxSIZE until the AxREADY handshake, then move to W or R on the next cycle.
REQ-022 W SHALL drive WVALID = wr_valid, wr_ready = WREADY and WDATA = wr_data as a combinational pass-through.
REQ-023 In W, WLAST SHALL equal (beat_cnt == len), and beat_cnt SHALL increment on each W handshake.
REQ-024 A handshake with WLAST high SHALL move the FSM to B.
REQ-025 B SHALL hold BREADY high; on BVALID it SHALL capture BRESP into resp, pulse done and return to IDLE.
REQ-026 R SHALL pass through RREADY = rd_ready, rd_valid = RVALID, rd_data = RDATA and rd_last = RLAST.
REQ-027 R SHALL accumulate resp as the maximum RRESP seen over the burst.
REQ-028 The R handshake with RLAST high SHALL pulse done on the next cycle and return to IDLE.
REQ-029 A slave RLAST arriving before len+1 beats, or missing at beat len+1, SHALL force resp = 2'b10; in both cases the burst SHALL end at RLAST.
REQ-030 done SHALL be a one-cycle pulse, and resp SHALL hold its value until the next command is accepted.
REQ-031 cmd_ready SHALL be low in every state except IDLE, including the cycle in which done pulses.

Reset
REQ-032 While ARESETn is low at a rising edge, the FSM SHALL enter IDLE.
REQ-033 While ARESETn is low at a rising edge, AWVALID, WVALID, BREADY, ARVALID, RREADY, done and rd_valid SHALL be 0, and resp, beat_cnt and the address/len/size registers SHALL be 0.
REQ-034 cmd_ready SHALL be 0 during reset and 1 in the first cycle after ARESETn goes high.
REQ-035 A reset mid-burst SHALL abandon the transaction without a done pulse.

Structure
REQ-036 The state enum, the AXI response constants (OKAY = 2'b00, SLVERR = 2'b10) and the 4 KB boundary mask SHALL live in a shared package, axi4_pkg.
REQ-037 The block SHALL be a single module with no sub-modules; the boundary and size checks SHALL be inline combinational logic.

Verification
REQ-038 Write burst of len 3, size 2 at 0x0010 with data 0xA0–0xA3 against the slave → 4 W beats, WLAST on the 4th beat only, done with resp 00.
REQ-039 Read-back of REQ-038 with len 3 → rd_data 0xA0–0xA3, rd_last on the 4th beat only, done with resp 00.
REQ-040 Write at 0x0FFC with len 1, size 2 (crosses 4 KB) → no AWVALID, done within 2 cycles with resp 10.
REQ-041 AWREADY held low for 5 cycles, and rd_ready toggled every cycle → AWADDR stays stable while waiting, and no read beat is lost or duplicated.
REQ-042 Read of 0x1000 (beyond memory depth) → RRESP 10 on every beat, final resp 10.
REQ-043 ARESETn pulled low during the 2nd W beat → all valids 0 at the next edge, cmd_ready 1 after release, and the next command completes normally.
